can_tx_sequencer: RTL and testbench

Hardware Avalon-MM master that drives the PeliCAN-mode register map of the on-chip CAN controller and sends one CAN frame per request without CPU involvement. It accepts a frame on a valid/ready port, waits for the transmit buffer to be free, loads the TX buffer, issues the transmit command, and polls for completion. It shares the controller's Avalon slave with the Nios II through the Qsys interconnect. It also reports a completion status.

---
 rtl/can_tx_pkg.sv | 78 +++++++
 rtl/can_avm_xfer.sv | 47 ++++
 rtl/can_tx_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_can_tx_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_tx_pkg.sv
// Shared definitions for the CAN TX sequencer: register map, SR bits, commands,
// FSM states, status codes, frame payload and TX-buffer byte layout helpers.
package can_tx_pkg;

    localparam logic [7:0] ADDR_CMR = 8'd1;
    localparam logic [7:0] ADDR_SR  = 8'd2;
    localparam logic [7:0] ADDR_TXB = 8'd16;

    localparam int unsigned SR_TBS = 2;
    localparam int unsigned SR_TCS = 3;

    localparam logic [7:0] CMD_TR = 8'h01;
    localparam logic [7:0] CMD_AT = 8'h02;

`ifdef CAN_TX_EXT_ID_EN
    localparam int unsigned ID_W = 29;
`else
    localparam int unsigned ID_W = 11;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL_TBS,
        ST_LOAD,
        ST_CMD,
        ST_POLL_TCS,
        ST_ABORT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        STAT_SENT   = 2'b00,
        STAT_NO_TBS = 2'b01,
        STAT_TX_TMO = 2'b10
    } status_t;

    typedef struct packed {
        logic [28:0] id;
        logic        ext;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } frame_t;

    function automatic logic [3:0] txb_hdr_len(input frame_t f);
        return f.ext ? 4'd5 : 4'd3;
    endfunction

    // Index of the final TX-buffer byte; DLC above 8 still loads only 8 bytes.
    function automatic logic [3:0] txb_last_idx(input frame_t f);
        logic [3:0] n;
        n = f.rtr ? 4'd0 : ((f.dlc > 4'd8) ? 4'd8 : f.dlc);
        return 4'(txb_hdr_len(f) + n - 4'd1);
    endfunction

    function automatic logic [7:0] txb_byte(input frame_t f, input logic [3:0] idx);
        logic [3:0] k;
        logic [7:0] b;
        k = 4'(idx - txb_hdr_len(f));
        b = 8'(f.data >> {k, 3'b000});
        if (idx == 4'd0) begin
            b = {f.ext, f.rtr, 2'b00, f.dlc};
        end else if (!f.ext) begin
            if (idx == 4'd1)      b = f.id[10:3];
            else if (idx == 4'd2) b = {f.id[2:0], f.rtr, 4'b0000};
        end else begin
            case (idx)
                4'd1:    b = f.id[28:21];
                4'd2:    b = f.id[20:13];
                4'd3:    b = f.id[12:5];
                4'd4:    b = {f.id[4:0], f.rtr, 2'b00};
                default: ;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/can_avm_xfer.sv
// Single-transfer Avalon-MM master: a start request launches one read or write,
// held until the slave drops waitrequest; done_c/rdata_c mark completion.
module can_avm_xfer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       done_c,
    output logic [7:0] rdata_c,
    output logic [7:0] avm_address,
    output logic       avm_chipselect,
    output logic       avm_write,
    output logic       avm_read,
    output logic [7:0] avm_writedata,
    input  logic [7:0] avm_readdata,
    input  logic       avm_waitrequest
);

    assign done_c  = avm_chipselect & ~avm_waitrequest;
    assign rdata_c = avm_readdata;

    // A start in the completion cycle chains the next transfer with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_writedata  <= '0;
        end else if (start) begin
            avm_address    <= addr;
            avm_chipselect <= 1'b1;
            avm_write      <= wr;
            avm_read       <= ~wr;
            avm_writedata  <= wr ? wdata : 8'h00;
        end else if (done_c) begin
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_writedata  <= '0;
        end
    end

endmodule

// File: rtl/can_tx_sequencer.sv
// Sends one CAN frame per request through the PeliCAN register map.
// Define CAN_TX_EXT_ID_EN for 29-bit extended identifiers (adds frm_ext).
module can_tx_sequencer
    import can_tx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic            csi_clk,
    input  logic            rsi_reset,
    output logic [7:0]      avm_address,
    output logic            avm_chipselect,
    output logic            avm_write,
    output logic            avm_read,
    output logic [7:0]      avm_writedata,
    input  logic [7:0]      avm_readdata,
    input  logic            avm_waitrequest,
    input  logic            frm_valid,
    output logic            frm_ready,
    input  logic [ID_W-1:0] frm_id,
`ifdef CAN_TX_EXT_ID_EN
    input  logic            frm_ext,
`endif
    input  logic            frm_rtr,
    input  logic [3:0]      frm_dlc,
    input  logic [63:0]     frm_data,
    output logic            busy,
    output logic            done,
    output logic [1:0]      status
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       TBS_MASK = 8'(1 << SR_TBS);
    localparam logic [7:0]       TCS_MASK = 8'(1 << SR_TCS);

    state_t           state;
    frame_t           frm;
    frame_t           frm_in_c;
    logic [3:0]       idx;
    logic [3:0]       nxt_idx_c;
    logic [CNT_W-1:0] cnt;
    logic             req_start_c;
    logic             req_wr_c;
    logic [7:0]       req_addr_c;
    logic [7:0]       req_wdata_c;
    logic             xfer_done_c;
    logic [7:0]       xfer_rdata_c;
    logic             in_flight_c;
    logic             tmo_c;
    logic             tbs_c;
    logic             tcs_c;

    always_comb begin
        frm_in_c      = '0;
        frm_in_c.id   = 29'(frm_id);
`ifdef CAN_TX_EXT_ID_EN
        frm_in_c.ext  = frm_ext;
`endif
        frm_in_c.rtr  = frm_rtr;
        frm_in_c.dlc  = frm_dlc;
        frm_in_c.data = frm_data;
    end

    // Timeout is only taken when no transfer is left hanging on the bus.
    assign in_flight_c = avm_chipselect & ~xfer_done_c;
    assign tmo_c       = (cnt >= CNT_LAST) & ~in_flight_c;
    assign tbs_c       = xfer_done_c & ((xfer_rdata_c & TBS_MASK) != 8'h00);
    assign tcs_c       = xfer_done_c & ((xfer_rdata_c & TCS_MASK) != 8'h00);
    assign nxt_idx_c   = idx + 4'd1;

    // Bus requests are decided in the cycle a transfer completes.
    always_comb begin
        req_start_c = 1'b0;
        req_wr_c    = 1'b0;
        req_addr_c  = ADDR_SR;
        req_wdata_c = 8'h00;
        case (state)
            ST_IDLE: req_start_c = frm_valid;
            ST_POLL_TBS: begin
                if (tbs_c) begin
                    req_start_c = 1'b1;
                    req_wr_c    = 1'b1;
                    req_addr_c  = ADDR_TXB;
                    req_wdata_c = txb_byte(frm, 4'd0);
                end else if (!tmo_c && !avm_chipselect) begin
                    req_start_c = 1'b1;
                end
            end
            ST_LOAD: begin
                if (xfer_done_c) begin
                    req_start_c = 1'b1;
                    req_wr_c    = 1'b1;
                    if (idx == txb_last_idx(frm)) begin
                        req_addr_c  = ADDR_CMR;
                        req_wdata_c = CMD_TR;
                    end else begin
                        req_addr_c  = ADDR_TXB + {4'b0000, nxt_idx_c};
                        req_wdata_c = txb_byte(frm, nxt_idx_c);
                    end
                end
            end
            ST_CMD: req_start_c = xfer_done_c;
            ST_POLL_TCS: begin
                if (tcs_c) begin
                    req_start_c = 1'b0;
                end else if (tmo_c) begin
                    req_start_c = 1'b1;
                    req_wr_c    = 1'b1;
                    req_addr_c  = ADDR_CMR;
                    req_wdata_c = CMD_AT;
                end else if (!avm_chipselect) begin
                    req_start_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state     <= ST_IDLE;
            frm       <= '0;
            idx       <= '0;
            cnt       <= '0;
            frm_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= STAT_SENT;
        end else begin
            done <= 1'b0;
            if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    if (frm_valid) begin
                        frm       <= frm_in_c;
                        state     <= ST_POLL_TBS;
                        cnt       <= '0;
                        frm_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_POLL_TBS: begin
                    if (tbs_c) begin
                        state <= ST_LOAD;
                        idx   <= '0;
                        cnt   <= '0;
                    end else if (tmo_c) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        status <= STAT_NO_TBS;
                        cnt    <= '0;
                    end
                end
                ST_LOAD: begin
                    if (xfer_done_c) begin
                        if (idx == txb_last_idx(frm)) begin
                            state <= ST_CMD;
                            cnt   <= '0;
                        end else begin
                            idx <= nxt_idx_c;
                        end
                    end
                end
                ST_CMD: begin
                    if (xfer_done_c) begin
                        state <= ST_POLL_TCS;
                        cnt   <= '0;
                    end
                end
                ST_POLL_TCS: begin
                    if (tcs_c) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        status <= STAT_SENT;
                        cnt    <= '0;
                    end else if (tmo_c) begin
                        state <= ST_ABORT;
                        cnt   <= '0;
                    end
                end
                ST_ABORT: begin
                    if (xfer_done_c) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        status <= STAT_TX_TMO;
                        cnt    <= '0;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    frm_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    can_avm_xfer u_xfer (
        .clk             (csi_clk),
        .rst             (rsi_reset),
        .start           (req_start_c),
        .wr              (req_wr_c),
        .addr            (req_addr_c),
        .wdata           (req_wdata_c),
        .done_c          (xfer_done_c),
        .rdata_c         (xfer_rdata_c),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

endmodule

// File: tb/tb_can_tx_sequencer.sv
// Bench for can_tx_sequencer: CAN register-slave model with random stalls and a
// frame-level reference of the expected TX-buffer/command write sequence.
module tb_can_tx_sequencer;

    localparam int unsigned T = 64;

    logic        csi_clk;
    logic        rsi_reset;
    logic [7:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic        avm_read;
    logic [7:0]  avm_writedata;
    logic [7:0]  avm_readdata;
    logic        avm_waitrequest;
    logic        frm_valid;
    logic        frm_ready;
    logic [10:0] frm_id;
    logic        frm_rtr;
    logic [3:0]  frm_dlc;
    logic [63:0] frm_data;
    logic        busy;
    logic        done;
    logic [1:0]  status;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int cfg_tbs   = 1;
    int cfg_tcs   = 1;
    int cfg_stall = 0;
    int rd_tbs    = 0;
    int rd_tcs    = 0;
    logic cmd_seen = 1'b0;
    logic [15:0] wr_q[$];

    can_tx_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .csi_clk         (csi_clk),
        .rsi_reset       (rsi_reset),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .frm_valid       (frm_valid),
        .frm_ready       (frm_ready),
        .frm_id          (frm_id),
        .frm_rtr         (frm_rtr),
        .frm_dlc         (frm_dlc),
        .frm_data        (frm_data),
        .busy            (busy),
        .done            (done),
        .status          (status)
    );

    initial begin
        csi_clk = 1'b0;
        forever #5 csi_clk = ~csi_clk;
    end

    always @(posedge csi_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_checks - n_fail, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Register slave: random stalls, holds-stable check, SR bits from the scenario.
    initial begin : slave
        int          stall_left;
        logic        in_xfer;
        logic [17:0] snap;
        logic [7:0]  sr;
        stall_left = 0;
        in_xfer    = 1'b0;
        snap       = '0;
        forever begin
            @(negedge csi_clk);
            avm_readdata = 8'($urandom);
            if (!avm_chipselect) begin
                check("idle_strobes", {avm_read, avm_write}, 2'b00);
                in_xfer         = 1'b0;
                avm_waitrequest = 1'($urandom);
            end else begin
                if (!in_xfer) begin
                    in_xfer    = 1'b1;
                    stall_left = (cfg_stall > 0) ? int'($urandom_range(cfg_stall, 0)) : 0;
                    snap       = {avm_address, avm_write, avm_read, avm_writedata};
                    check("one_strobe", avm_read ^ avm_write, 1'b1);
                    if (avm_read) check("rd_addr", avm_address, 8'd2);
                end else begin
                    check("hold_stable", {avm_address, avm_write, avm_read, avm_writedata}, snap);
                end
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    in_xfer         = 1'b0;
                    if (avm_write) begin
                        wr_q.push_back({avm_address, avm_writedata});
                        if (avm_address == 8'd1 && avm_writedata == 8'h01) cmd_seen = 1'b1;
                    end else begin
                        sr = 8'($urandom);
                        if (!cmd_seen) begin
                            rd_tbs++;
                            sr[2] = (cfg_tbs != 0) && (rd_tbs >= cfg_tbs);
                        end else begin
                            rd_tcs++;
                            sr[3] = (cfg_tcs != 0) && (rd_tcs >= cfg_tcs);
                        end
                        avm_readdata = sr;
                    end
                end
            end
        end
    end

    // tbs_after/tcs_after: SR poll on which the bit first reads set (0 = never).
    task automatic run_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] data, input int tbs_after, input int tcs_after,
                             input int stall);
        logic [15:0] exp_q[$];
        int          n_data;
        int          acc_cyc;
        int          exp_lat;
        int          waited;
        logic [1:0]  exp_st;
        logic        seen;
        exp_q.delete();
        n_data = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        if (tbs_after != 0) begin
            exp_q.push_back({8'd16, 1'b0, rtr, 2'b00, dlc});
            exp_q.push_back({8'd17, id[10:3]});
            exp_q.push_back({8'd18, id[2:0], rtr, 4'b0000});
            for (int i = 0; i < n_data; i++) exp_q.push_back({8'(19 + i), 8'(data >> (8 * i))});
            exp_q.push_back({8'd1, 8'h01});
            if (tcs_after == 0) exp_q.push_back({8'd1, 8'h02});
        end
        exp_st  = (tbs_after == 0) ? 2'b01 : (tcs_after == 0) ? 2'b10 : 2'b00;
        exp_lat = 4 + 3 + n_data + 2 * (tbs_after - 1) + 2 * (tcs_after - 1);

        wr_q.delete();
        rd_tbs    = 0;
        rd_tcs    = 0;
        cmd_seen  = 1'b0;
        cfg_tbs   = tbs_after;
        cfg_tcs   = tcs_after;
        cfg_stall = stall;

        @(negedge csi_clk);
        check("ready_idle", frm_ready, 1'b1);
        frm_id    = id;
        frm_rtr   = rtr;
        frm_dlc   = dlc;
        frm_data  = data;
        frm_valid = 1'b1;
        acc_cyc   = cyc;
        @(negedge csi_clk);
        frm_valid = 1'b0;
        frm_id    = 11'($urandom);
        frm_rtr   = 1'($urandom);
        frm_dlc   = 4'($urandom);
        frm_data  = {$urandom, $urandom};
        check("busy_after_accept", {busy, frm_ready}, 2'b10);

        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 2000) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge csi_clk);
                waited++;
            end
        end
        check("done_seen", seen, 1'b1);
        check("status", status, exp_st);
        check("wr_count", wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check($sformatf("wr%0d", i), wr_q[i], exp_q[i]);
        if (stall == 0 && tbs_after != 0 && tcs_after != 0)
            check("latency", cyc - acc_cyc, exp_lat);
        if (tbs_after == 0)
            check("tbs_tmo_bound", (cyc - acc_cyc) <= int'(T) + 1 + ((stall != 0) ? 6 : 0), 1'b1);

        @(negedge csi_clk);
        check("post_done", {done, frm_ready, busy}, 3'b010);
    endtask

    initial begin
        int waited;
        int n_cmr;
        int ta;
        int tc;
        rsi_reset       = 1'b1;
        frm_valid       = 1'b0;
        frm_id          = '0;
        frm_rtr         = 1'b0;
        frm_dlc         = '0;
        frm_data        = '0;
        avm_readdata    = '0;
        avm_waitrequest = 1'b0;
        repeat (3) @(posedge csi_clk);
        @(negedge csi_clk);
        check("rst_avm", {avm_address, avm_chipselect, avm_write, avm_read, avm_writedata}, 0);
        check("rst_ready", frm_ready, 1'b1);
        check("rst_flags", {busy, done, status}, 4'b0000);
        rsi_reset = 1'b0;

        run_frame(11'h123, 1'b0, 4'd8, 64'h0807060504030201, 1, 3, 0);
        run_frame(11'h5A3, 1'b1, 4'd4, {$urandom, $urandom}, 1, 1, 0);
        run_frame(11'h2F0, 1'b0, 4'd3, {$urandom, $urandom}, 0, 1, 0);
        run_frame(11'h0AB, 1'b0, 4'd12, {$urandom, $urandom}, 1, 0, 0);
        run_frame(11'h123, 1'b0, 4'd8, 64'h0807060504030201, 2, 3, 5);

        // Reset in the middle of loading the TX buffer.
        wr_q.delete();
        rd_tbs    = 0;
        rd_tcs    = 0;
        cmd_seen  = 1'b0;
        cfg_tbs   = 1;
        cfg_tcs   = 1;
        cfg_stall = 0;
        @(negedge csi_clk);
        frm_id    = 11'h2A5;
        frm_rtr   = 1'b0;
        frm_dlc   = 4'd8;
        frm_data  = 64'h1122334455667788;
        frm_valid = 1'b1;
        @(negedge csi_clk);
        frm_valid = 1'b0;
        waited = 0;
        while (wr_q.size() < 4 && waited < 100) begin
            @(negedge csi_clk);
            waited++;
        end
        check("reach_load", wr_q.size() >= 4, 1'b1);
        rsi_reset = 1'b1;
        @(negedge csi_clk);
        check("mid_rst_avm", {avm_address, avm_chipselect, avm_write, avm_read, avm_writedata}, 0);
        check("mid_rst_flags", {frm_ready, busy, done}, 3'b100);
        rsi_reset = 1'b0;
        repeat (4) @(negedge csi_clk);
        n_cmr = 0;
        foreach (wr_q[i]) if (wr_q[i][15:8] == 8'd1) n_cmr++;
        check("no_cmd_after_rst", n_cmr, 0);
        check("bus_quiet_after_rst", avm_chipselect, 1'b0);
        run_frame(11'h7FF, 1'b0, 4'd5, {$urandom, $urandom}, 1, 2, 0);

        for (int f = 0; f < 24; f++) begin
            ta = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(3, 1));
            tc = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(4, 1));
            run_frame(11'($urandom), 1'($urandom_range(3, 0) == 0), 4'($urandom),
                      {$urandom, $urandom}, ta, tc, int'($urandom_range(5, 0)));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
